seg_display_sched: RTL and testbench

- Owns the six 7-segment digits of the platform and shares them between two sources: a host write port (valid/ready) and a local 6-digit BCD run counter.
- Switches select which source is shown, or pause/blank the display. The pushbutton, debounced here, clears the counter.
- Sits between the raw board I/O (button, 2 switches, six hex outputs) and the host/bus side.

---
 rtl/seg_display_sched.sv | 215 +++++++++++++++++++++
 tb/tb_seg_display_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_sched.sv
// Six-digit 7-segment scheduler: shares the display between a host write buffer
// and a BCD run counter that a debounced pushbutton clears.
module seg_display_sched #(
  parameter int unsigned TICK_DIV        = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        button_n,
  input  logic [1:0]  mode_sw,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [2:0]  host_digit,
  input  logic [3:0]  host_value,
  output logic        host_err,
  output logic [23:0] count_bcd,
  output logic        wrap,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam int unsigned PRE_W    = $clog2(TICK_DIV);
  localparam int unsigned DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned N_DIGITS = 6;

  localparam logic [1:0] MODE_HOST  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_PAUSE = 2'b10;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {DB_UP, DB_WAIT_DN, DB_DOWN, DB_WAIT_UP} db_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [1:0]       btn_sync_q;
  logic [1:0]       mode_s1_q, mode_s2_q;
  logic             btn_s;
  logic [1:0]       mode_s;
  db_state_e        db_state_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic             press_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [23:0]      count_q, count_d, count_inc;
  logic             wrap_q, wrap_d;
  logic             tick_c;
  logic             host_ready_q, host_err_q;
  logic             xfer_c;
  logic [3:0]       buf_q [N_DIGITS];
  logic [6:0]       hex_q [N_DIGITS];
  logic [6:0]       hex_d [N_DIGITS];

  // Two-flop synchronizers for the asynchronous board inputs
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      btn_sync_q <= 2'b11;
      mode_s1_q  <= MODE_HOST;
      mode_s2_q  <= MODE_HOST;
    end else begin
      btn_sync_q <= {btn_sync_q[0], button_n};
      mode_s1_q  <= mode_sw;
      mode_s2_q  <= mode_s1_q;
    end
  end

  assign btn_s  = btn_sync_q[1];
  assign mode_s = mode_s2_q;

  // Debounce FSM; press_q pulses once per accepted press, never on release
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      db_state_q <= DB_UP;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (db_state_q)
        DB_UP: begin
          if (!btn_s) begin
            db_state_q <= DB_WAIT_DN;
            db_cnt_q   <= '0;
          end
        end
        DB_WAIT_DN: begin
          if (btn_s) begin
            db_state_q <= DB_UP;
          end else if (db_cnt_q == DB_LAST) begin
            db_state_q <= DB_DOWN;
            press_q    <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
          end
        end
        DB_DOWN: begin
          if (btn_s) begin
            db_state_q <= DB_WAIT_UP;
            db_cnt_q   <= '0;
          end
        end
        DB_WAIT_UP: begin
          if (!btn_s) begin
            db_state_q <= DB_DOWN;
          end else if (db_cnt_q == DB_LAST) begin
            db_state_q <= DB_UP;
          end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
          end
        end
        default: db_state_q <= DB_UP;
      endcase
    end
  end

  // BCD increment with ripple carry across the six digits
  always_comb begin
    logic carry;
    carry     = 1'b1;
    count_inc = count_q;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign tick_c = (mode_s == MODE_RUN) && (pre_q == PRE_LAST);

  // Prescaler/counter next state; a press overrides a coincident tick
  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (press_q) begin
      pre_d   = '0;
      count_d = '0;
    end else if (tick_c) begin
      pre_d   = '0;
      count_d = count_inc;
      wrap_d  = (count_q == 24'h999999);
    end else if (mode_s == MODE_RUN) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  assign xfer_c = host_valid && host_ready_q;

  // Display source select
  always_comb begin
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      hex_d[i] = 7'h7F;
      if (mode_s == MODE_HOST) begin
        hex_d[i] = seg_decode(buf_q[i]);
      end else if ((mode_s == MODE_RUN) || (mode_s == MODE_PAUSE)) begin
        hex_d[i] = seg_decode(count_q[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pre_q        <= '0;
      count_q      <= '0;
      wrap_q       <= 1'b0;
      host_ready_q <= 1'b0;
      host_err_q   <= 1'b0;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        buf_q[i] <= 4'h0;
        hex_q[i] <= 7'h7F;
      end
    end else begin
      pre_q        <= pre_d;
      count_q      <= count_d;
      wrap_q       <= wrap_d;
      host_ready_q <= (mode_s == MODE_HOST);
      host_err_q   <= xfer_c && (host_digit > 3'd5);
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        if (xfer_c && (host_digit == 3'(i))) begin
          buf_q[i] <= host_value;
        end
        hex_q[i] <= hex_d[i];
      end
    end
  end

  assign host_ready = host_ready_q;
  assign host_err   = host_err_q;
  assign count_bcd  = count_q;
  assign wrap       = wrap_q;
  assign hex0       = hex_q[0];
  assign hex1       = hex_q[1];
  assign hex2       = hex_q[2];
  assign hex3       = hex_q[3];
  assign hex4       = hex_q[4];
  assign hex5       = hex_q[5];

endmodule

// File: tb/tb_seg_display_sched.sv
// Bench for seg_display_sched: cycle-level behavioural model compared every cycle,
// plus literal expectations from the directed scenarios and randomized traffic.
module tb_seg_display_sched;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        button_n = 1'b1;
  logic [1:0]  mode_sw = 2'b00;
  logic        host_valid = 1'b0;
  logic [2:0]  host_digit = 3'd0;
  logic [3:0]  host_value = 4'd0;
  logic        host_ready, host_err, wrap;
  logic [23:0] count_bcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [41:0] hex_all;

  assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

  seg_display_sched #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .button_n(button_n), .mode_sw(mode_sw),
    .host_valid(host_valid), .host_ready(host_ready), .host_digit(host_digit),
    .host_value(host_value), .host_err(host_err), .count_bcd(count_bcd), .wrap(wrap),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  initial forever #5 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int wrap_seen = 0;
  bit chk_en = 1'b0;
  bit preload_req = 1'b0;

  // Behavioural model state
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] m_hex [6];
  logic [3:0] m_buf [6];
  bit         m_ready, m_err, m_wrap, m_press, m_acc;
  int         m_count, m_pre, m_run;
  bit         m_b0, m_b1;
  logic [1:0] m_m0, m_m1;

  function automatic logic [23:0] to_bcd(input int n);
    logic [23:0] r;
    int v;
    v = n;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_hex[i] = 7'h7F;
      m_buf[i] = 4'h0;
    end
    m_ready = 0; m_err = 0; m_wrap = 0; m_press = 0; m_acc = 1;
    m_count = 0; m_pre = 0; m_run = 0;
    m_b0 = 1; m_b1 = 1; m_m0 = 2'b00; m_m1 = 2'b00;
  endtask

  task automatic model_step();
    bit         bs, xfer, newp;
    logic [1:0] ms;
    logic [23:0] bcd;
    bs  = m_b1;
    ms  = m_m1;
    bcd = to_bcd(m_count);
    for (int i = 0; i < 6; i++) begin
      if (ms == 2'b00)      m_hex[i] = seg_tab[m_buf[i]];
      else if (ms == 2'b11) m_hex[i] = 7'h7F;
      else                  m_hex[i] = seg_tab[bcd[4*i +: 4]];
    end
    xfer  = host_valid && m_ready;
    m_err = xfer && (host_digit > 3'd5);
    if (xfer && host_digit <= 3'd5) m_buf[host_digit] = host_value;
    m_ready = (ms == 2'b00);
    m_wrap  = 0;
    if (m_press) begin
      m_count = 0;
      m_pre   = 0;
    end else if (ms == 2'b01) begin
      m_pre = (m_pre + 1) % TICK_DIV;
      if (m_pre == 0) begin
        m_wrap  = (m_count == 999999);
        m_count = (m_count + 1) % 1000000;
      end
    end
    // Accept a level change once it has differed from the accepted level DEB+1 cycles
    newp = 0;
    if (bs != m_acc) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_acc = bs;
        m_run = 0;
        newp  = !bs;
      end
    end else begin
      m_run = 0;
    end
    m_press = newp;
    m_b1 = m_b0; m_b0 = button_n;
    m_m1 = m_m0; m_m0 = mode_sw;
  endtask

  // Model advances on every DUT edge
  initial begin
    forever begin
      @(posedge clk_clk or posedge reset_reset);
      if (reset_reset) begin
        model_reset();
      end else begin
        model_step();
        if (preload_req) begin
          #1;
          force dut.count_q = 24'h999999;
          m_count = 999999;
          #1;
          release dut.count_q;
          preload_req = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk_clk);
      if (chk_en) begin
        for (int i = 0; i < 6; i++)
          chk($sformatf("hex%0d", i), 32'(hex_all[7*i +: 7]), 32'(m_hex[i]));
        chk("host_ready", 32'(host_ready), 32'(m_ready));
        chk("host_err", 32'(host_err), 32'(m_err));
        chk("count_bcd", 32'(count_bcd), 32'(to_bcd(m_count)));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        if (host_err) err_seen++;
        if (wrap) wrap_seen++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_clk);
    #2;
  endtask

  task automatic host_write(input logic [2:0] d, input logic [3:0] v);
    host_valid = 1; host_digit = d; host_value = v;
    cyc(1);
    host_valid = 0;
  endtask

  task automatic chk_all_hex(input string name, input logic [6:0] exp);
    for (int i = 0; i < 6; i++) chk($sformatf("%s%0d", name, i), 32'(hex_all[7*i +: 7]), 32'(exp));
  endtask

  int snap;

  initial begin
    cyc(1);
    chk_en = 1;
    cyc(2);
    chk_all_hex("rst_hex", 7'h7F);
    chk("rst_ready", 32'(host_ready), 32'd0);
    chk("rst_count", 32'(count_bcd), 32'd0);
    reset_reset = 0;
    cyc(2);
    chk_all_hex("post_rst_hex", 7'h40);
    chk("post_rst_ready", 32'(host_ready), 32'd1);

    snap = err_seen;
    host_write(3'd2, 4'h8);
    host_write(3'd5, 4'hA);
    host_write(3'd7, 4'h3);
    cyc(4);
    chk("err_pulses", 32'(err_seen - snap), 32'd1);
    chk("host_hex2", 32'(hex2), 32'h00);
    chk("host_hex5", 32'(hex5), 32'h08);
    chk("host_hex0", 32'(hex0), 32'h40);
    chk("host_hex3", 32'(hex3), 32'h40);

    mode_sw = 2'b01; cyc(40);
    mode_sw = 2'b10; cyc(4);
    chk("run40_count", 32'(count_bcd), 32'h10);
    chk("run40_hex0", 32'(hex0), 32'h40);
    chk("run40_hex1", 32'(hex1), 32'h79);
    cyc(20);
    chk("pause_count", 32'(count_bcd), 32'h10);
    mode_sw = 2'b01; cyc(6);
    mode_sw = 2'b10; cyc(20);
    chk("run6_count", 32'(count_bcd), 32'h11);
    mode_sw = 2'b01; cyc(2);
    mode_sw = 2'b10; cyc(4);
    chk("phase_kept", 32'(count_bcd), 32'h12);

    preload_req = 1;
    cyc(2);
    chk("preload", 32'(count_bcd), 32'h999999);
    snap = wrap_seen;
    mode_sw = 2'b01; cyc(6);
    mode_sw = 2'b10; cyc(5);
    chk("wrap_count", 32'(count_bcd), 32'h0);
    chk("wrap_pulses", 32'(wrap_seen - snap), 32'd1);
    chk_all_hex("wrap_hex", 7'h40);

    mode_sw = 2'b01; cyc(8);
    mode_sw = 2'b10; cyc(4);
    chk("pre_btn_count", 32'(count_bcd), 32'h2);
    button_n = 0; cyc(2);
    button_n = 1; cyc(10);
    chk("short_press", 32'(count_bcd), 32'h2);
    button_n = 0; cyc(5);
    button_n = 1; cyc(10);
    chk("long_press", 32'(count_bcd), 32'h0);

    mode_sw = 2'b01; cyc(3);
    for (int off = 0; off < 4; off++) begin
      button_n = 0; cyc(5);
      button_n = 1; cyc(6 + off);
    end
    button_n = 0; cyc(12);
    button_n = 1; cyc(12);
    mode_sw = 2'b10; cyc(4);

    mode_sw = 2'b11; cyc(4);
    chk_all_hex("blank_hex", 7'h7F);
    chk("blank_ready", 32'(host_ready), 32'd0);
    snap = err_seen;
    host_write(3'd1, 4'hF);
    host_write(3'd7, 4'h1);
    mode_sw = 2'b00; cyc(4);
    chk("blank_err", 32'(err_seen - snap), 32'd0);
    chk("kept_hex1", 32'(hex1), 32'h40);
    chk("kept_hex2", 32'(hex2), 32'h00);
    chk("kept_hex5", 32'(hex5), 32'h08);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) button_n = ~button_n;
      if ($urandom_range(0, 39) == 0) mode_sw = 2'($urandom_range(0, 3));
      host_valid  = ($urandom_range(0, 2) == 0);
      host_digit  = 3'($urandom_range(0, 7));
      host_value  = 4'($urandom_range(0, 15));
      reset_reset = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    reset_reset = 0;
    host_valid  = 0;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
